pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-load and instruction-fetch end of the multi-cycle controller interface. Takes a byte-stream program image into instruction BRAM,
//  then holds the word-addressed PC and presents the current instruction (opcode/funct fields) to the controller.
//  Consumes the controller's write_pc strobe, cp_type and enbranch to compute the next PC.
// PARAMETERS
//  IMEM_AW   14  instruction memory address width (words); PC width
//  RESET_PC  0   word address of first instruction after load
// PORTS
//  clk         in   1        single clock; all logic on posedge
//  rst         in   1        synchronous, active-high reset
//  load_valid  in   1        program byte available
//  load_data   in   8        program byte
//  load_ready  out  1        byte accepted when load_valid&load_ready
//  write_pc    in   1        controller strobe: commit next PC (one-cycle pulse)
//  cp_type     in   2        00 seq, 01 register/halt, 10 jump, 11 cond. branch
//  enbranch    in   1        branch condition, sampled with write_pc when cp_type=11
//  jr_addr     in   IMEM_AW  register-sourced target for cp_type=01
//  instr       out  32       current instruction word
//  opecode     out  6        instr[31:26]
//  funct       out  6        instr[5:0]
//  instr_valid out  1        instr reflects mem[pc]
//  pc          out  IMEM_AW  current PC
//  link_pc     out  IMEM_AW  pc+1 (for jal link)
//  running     out  1        high in RUN
//  retired     out  32       instructions committed (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=LOAD_HDR, pc=RESET_PC, instr=32'hFFFF_FFFF (halt opcode), instr_valid=0, running=0, load_ready=1, retired=0.
//   BRAM contents not cleared.
//  While not RUN, instr forced to 32'hFFFF_FFFF so controller idles; write_pc ignored.
//  LOAD_HDR: 4 bytes big-endian = word count N. N==0 -> PRIME.
//  LOAD_BODY: 4 bytes per word, big-endian, written to addr RESET_PC+k (mod 2^IMEM_AW; excess words overwrite).
//   Write occurs the cycle after the 4th byte handshake. After word N -> PRIME. load_ready=0 outside LOAD_*.
//  PRIME: issue BRAM read at pc; 1-cycle read latency; next cycle instr=mem[pc], instr_valid=1, -> RUN.
//  RUN: on write_pc (cycle t) next PC:
//   00 pc+1; 10 instr[IMEM_AW-1:0]; 11 enbranch ? pc+1+sext(instr[15:0]) : pc+1;
//   01 with opecode!=6'h3F -> jr_addr; 01 with opecode==6'h3F -> HALT, pc unchanged.
//  All PC arithmetic mod 2^IMEM_AW (wrap silently).
//  PC updates at t+1; instr_valid=0 at t+1; new instr and instr_valid=1 at t+2.
//   The controller does not sample instr before t+3.
//  write_pc while instr_valid=0: ignored (protocol error; no PC change).
//  HALT: running=0, instr=32'hFFFF_FFFF; exits only by rst (rst re-enters LOAD_HDR).
//  rst mid-load: partial word discarded, count restarts; words already written stay in BRAM.
// CONFIGURATION
//  INSTR_COUNT_EN defined: retired increments on each accepted write_pc in RUN (incl. the halting one); wraps at 2^32.
//  Not defined: retired tied to 32'd0; no counter logic.
// STRUCTURE
//  Shared header cpu_defs.vh: OP_RTYPE=6'h00, OP_HALT=6'h3F, OP_J, OP_JAL, OP_BEQ, OP_BNE; CP_SEQ/CP_REG/CP_JUMP/CP_BRANCH encodings;
//   HALT_WORD=32'hFFFF_FFFF; fetch state encodings.
//  Sub-module imem_bram: 1 write port + 1 read port, registered read (1 cycle), 2^IMEM_AW x 32.
//  FSM: LOAD_HDR, LOAD_BODY, PRIME, RUN, HALT; byte counter (2b), word counter (32b).
// TESTING
//  Load 00 00 00 02, 20 01 00 05, FF FF FF FF -> mem[0]=0x20010005, mem[1]=0xFFFFFFFF; RUN; opecode=6'h08, instr_valid 2 cycles after PRIME entry.
//  RUN pc=5, instr=0x1000FFFE, cp_type=11, enbranch=1, write_pc -> pc=4 (5+1-2); repeat with enbranch=0 -> pc=6.
//  cp_type=01, opecode=0, jr_addr=0x123, write_pc -> pc=0x123, instr_valid low 1 cycle then mem[0x123].
//  Fetch of 0xFFFFFFFF, cp_type=01, write_pc -> HALT, running=0, later write_pc ignored, pc frozen.
//  rst after 6 body bytes -> load_ready=1, fresh header expected; earlier full word remains in BRAM.
//  INSTR_COUNT_EN: 3 seq write_pc + halt -> retired=4; without macro retired=0 throughout.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the program-load / instruction-fetch unit:
// opcodes, PC-update (cp_type) encodings, the halt word and fetch FSM states.
package pc_fetch_unit_pkg;

  // Opcode field values the controller and fetch unit agree on.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // Word presented to the controller whenever no real instruction is live.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  // How the controller asks for the next PC on a write_pc strobe.
  typedef enum logic [1:0] {
    CP_SEQ    = 2'b00,  // pc + 1
    CP_REG    = 2'b01,  // jr_addr, or halt when the opcode is OP_HALT
    CP_JUMP   = 2'b10,  // absolute target from the instruction
    CP_BRANCH = 2'b11   // pc + 1 + offset when enbranch is set
  } cp_type_e;

  typedef enum logic [2:0] {
    ST_LOAD_HDR  = 3'd0,
    ST_LOAD_BODY = 3'd1,
    ST_PRIME     = 3'd2,
    ST_RUN       = 3'd3,
    ST_HALT      = 3'd4
  } fetch_state_e;

  // Sign-extend a 16-bit branch displacement to 32 bits.
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_imem.sv
// Instruction memory: 2^AW x 32, one write port and one read port with a
// registered (one-cycle latency) read. The read data holds between reads.
module imem_bram #(
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  // NOTE: the storage array has no reset; a BRAM cannot be cleared in one
  // cycle, and the program image is expected to survive a controller reset.
  logic [31:0] mem_q [0:(1<<AW)-1];
  logic [31:0] rdata_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port; output only changes when a read is issued.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: loads a big-endian byte-stream program image (32-bit word
// count header, then the words) into instruction memory, then holds the
// word-addressed PC and presents mem[pc] to the multi-cycle controller.
// Optional feature: define INSTR_COUNT_EN to enable the retired-instruction
// counter; otherwise retired is tied to zero.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned          IMEM_AW  = 14,
  parameter logic [IMEM_AW-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [7:0]         load_data,
  output logic               load_ready,
  input  logic               write_pc,
  input  logic [1:0]         cp_type,
  input  logic               enbranch,
  input  logic [IMEM_AW-1:0] jr_addr,
  output logic [31:0]        instr,
  output logic [5:0]         opecode,
  output logic [5:0]         funct,
  output logic               instr_valid,
  output logic [IMEM_AW-1:0] pc,
  output logic [IMEM_AW-1:0] link_pc,
  output logic               running,
  output logic [31:0]        retired
);

  localparam logic [IMEM_AW-1:0] PC_ONE = IMEM_AW'(1);

  fetch_state_e       state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        shift_q, shift_d;
  logic [31:0]        word_cnt_q, word_cnt_d;
  logic [31:0]        word_total_q, word_total_d;
  logic               wr_en_q, wr_en_d;
  logic [IMEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fetch_q, fetch_d;

  logic               load_fire;
  logic [31:0]        full_word;
  logic               accept;
  logic               rd_en;
  logic [31:0]        rdata;
  logic [IMEM_AW-1:0] pc_seq;
  logic [IMEM_AW-1:0] br_off;

  assign load_ready = (state_q == ST_LOAD_HDR) || (state_q == ST_LOAD_BODY);
  assign load_fire  = load_valid && load_ready;
  assign full_word  = {shift_q, load_data};

  // A write_pc only counts when the current instruction is live.
  assign accept = (state_q == ST_RUN) && write_pc && instr_valid_q;

  // PRIME waits out a pending last-word write so it never reads stale data.
  assign rd_en = ((state_q == ST_PRIME) && !wr_en_q) ||
                 ((state_q == ST_RUN) && fetch_q);

  assign pc_seq = pc_q + PC_ONE;
  assign br_off = IMEM_AW'(sext16(rdata[15:0]));

  imem_bram #(.AW(IMEM_AW)) u_imem (
    .clk     (clk),
    .we_i    (wr_en_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data_q),
    .re_i    (rd_en),
    .raddr_i (pc_q),
    .rdata_o (rdata)
  );

  // Next-state logic: program load, priming read, and PC update in RUN.
  always_comb begin
    // NOTE: every variable gets its default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    word_cnt_d    = word_cnt_q;
    word_total_d  = word_total_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    instr_valid_d = instr_valid_q;
    fetch_d       = 1'b0;

    unique case (state_q)
      ST_LOAD_HDR: begin
        if (load_fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], load_data};
          if (byte_cnt_q == 2'd3) begin
            word_total_d = full_word;
            word_cnt_d   = 32'd0;
            state_d      = (full_word == 32'd0) ? ST_PRIME : ST_LOAD_BODY;
          end
        end
      end

      ST_LOAD_BODY: begin
        if (load_fire) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], load_data};
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = RESET_PC + word_cnt_q[IMEM_AW-1:0];
            wr_data_d  = full_word;
            word_cnt_d = word_cnt_q + 32'd1;
            if ((word_cnt_q + 32'd1) == word_total_q) state_d = ST_PRIME;
          end
        end
      end

      ST_PRIME: begin
        if (!wr_en_q) begin
          state_d       = ST_RUN;
          instr_valid_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (fetch_q) instr_valid_d = 1'b1;
        if (accept) begin
          instr_valid_d = 1'b0;
          fetch_d       = 1'b1;
          unique case (cp_type_e'(cp_type))
            CP_SEQ:    pc_d = pc_seq;
            CP_JUMP:   pc_d = rdata[IMEM_AW-1:0];
            CP_BRANCH: pc_d = enbranch ? (pc_seq + br_off) : pc_seq;
            CP_REG: begin
              if (rdata[31:26] == OP_HALT) begin
                state_d = ST_HALT;
                fetch_d = 1'b0;
              end else begin
                pc_d = jr_addr;
              end
            end
            default: pc_d = pc_seq;
          endcase
        end
      end

      ST_HALT: begin
        instr_valid_d = 1'b0;
      end

      default: state_d = ST_LOAD_HDR;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q       <= ST_LOAD_HDR;
      pc_q          <= RESET_PC;
      byte_cnt_q    <= 2'd0;
      shift_q       <= 24'd0;
      word_cnt_q    <= 32'd0;
      word_total_q  <= 32'd0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 32'd0;
      instr_valid_q <= 1'b0;
      fetch_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      word_cnt_q    <= word_cnt_d;
      word_total_q  <= word_total_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      instr_valid_q <= instr_valid_d;
      fetch_q       <= fetch_d;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] retired_q;

  // Count every accepted write_pc in RUN, including the halting one.
  always_ff @(posedge clk) begin
    if (rst)         retired_q <= 32'd0;
    else if (accept) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`else
  assign retired = 32'd0;
`endif

  // The controller only ever sees a real instruction while running.
  assign running     = (state_q == ST_RUN);
  assign instr       = running ? rdata : HALT_WORD;
  assign opecode     = instr[31:26];
  assign funct       = instr[5:0];
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign link_pc     = pc_seq;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: program load, priming latency, every
// cp_type path, halt behaviour, reset during load and the retired counter.
module tb_pc_fetch_unit;

`ifdef INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        write_pc;
  logic [1:0]  cp_type;
  logic        enbranch;
  logic [13:0] jr_addr;
  logic [31:0] instr;
  logic [5:0]  opecode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [13:0] pc;
  logic [13:0] link_pc;
  logic        running;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] img [0:291];

  pc_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .write_pc    (write_pc),
    .cp_type     (cp_type),
    .enbranch    (enbranch),
    .jr_addr     (jr_addr),
    .instr       (instr),
    .opecode     (opecode),
    .funct       (funct),
    .instr_valid (instr_valid),
    .pc          (pc),
    .link_pc     (link_pc),
    .running     (running),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (load_ready !== 1'b1) check("load_ready_hs", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Bounded wait for instr_valid; returns the number of cycles waited.
  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (instr_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check(tag, 32'(instr_valid), 32'd1);
  endtask

  // One accepted write_pc, then the two-cycle refetch.
  task automatic commit(input string tag, input logic [1:0] cp, input logic en,
                        input logic [13:0] jr, input logic [13:0] exp_pc,
                        input logic [31:0] exp_instr);
    write_pc = 1'b1;
    cp_type  = cp;
    enbranch = en;
    jr_addr  = jr;
    tick();
    write_pc = 1'b0;
    check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    check({tag, "_vlow"}, 32'(instr_valid), 32'd0);
    tick();
    check({tag, "_vhigh"}, 32'(instr_valid), 32'd1);
    check({tag, "_instr"}, instr, exp_instr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst = 1'b1; load_valid = 1'b0; load_data = 8'h00; write_pc = 1'b0;
    cp_type = 2'b00; enbranch = 1'b0; jr_addr = '0;
    tick();
    do_reset();

    // Reset state.
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_instr", instr, 32'hFFFF_FFFF);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_retired", retired, 32'd0);

    // Phase A: two-word program, sequential step, held strobe, halt.
    send_word(32'd2);
    send_word(32'h2001_0005);
    send_word(32'hFFFF_FFFF);
    check("prime_load_ready", 32'(load_ready), 32'd0);
    check("prime_instr", instr, 32'hFFFF_FFFF);
    wait_valid("a_valid", cyc);
    check("prime_latency", 32'(cyc), 32'd2);
    check("a_running", 32'(running), 32'd1);
    check("a_instr", instr, 32'h2001_0005);
    check("a_opecode", 32'(opecode), 32'h08);
    check("a_funct", 32'(funct), 32'h05);
    check("a_pc", 32'(pc), 32'd0);
    check("a_link", 32'(link_pc), 32'd1);

    // Strobe held for two cycles: second one lands while instr_valid=0.
    write_pc = 1'b1; cp_type = 2'b00;
    tick();
    check("hold_pc1", 32'(pc), 32'd1);
    check("hold_vlow", 32'(instr_valid), 32'd0);
    tick();
    write_pc = 1'b0;
    check("hold_ignored_pc", 32'(pc), 32'd1);
    check("hold_vhigh", 32'(instr_valid), 32'd1);
    check("a_mem1", instr, 32'hFFFF_FFFF);

    // Halt on the 0xFFFFFFFF word.
    write_pc = 1'b1; cp_type = 2'b01;
    tick();
    write_pc = 1'b0;
    check("halt_running", 32'(running), 32'd0);
    check("halt_instr", instr, 32'hFFFF_FFFF);
    check("halt_pc", 32'(pc), 32'd1);
    check("halt_retired", retired, CNT_EN ? 32'd2 : 32'd0);
    write_pc = 1'b1; cp_type = 2'b00;
    tick();
    write_pc = 1'b0;
    tick();
    check("halt_frozen_pc", 32'(pc), 32'd1);
    check("halt_stays", 32'(running), 32'd0);
    check("halt_retired2", retired, CNT_EN ? 32'd2 : 32'd0);

    // Phase B: reset in the middle of the second body word.
    do_reset();
    check("b_rst_pc", 32'(pc), 32'd0);
    check("b_rst_retired", retired, 32'd0);
    send_word(32'd3);
    send_word(32'hAABB_CCDD);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("b_load_ready", 32'(load_ready), 32'd1);
    check("b_running", 32'(running), 32'd0);
    send_word(32'd0);
    wait_valid("b_valid", cyc);
    check("b_mem0_kept", instr, 32'hAABB_CCDD);
    commit("b_seq", 2'b00, 1'b0, '0, 14'd1, 32'hFFFF_FFFF);

    // Phase C: larger image exercising every cp_type.
    for (int i = 0; i < 292; i++) img[i] = 32'h0000_0000;
    img[3]     = 32'h0800_0005;
    img[4]     = 32'h0800_0005;
    img[5]     = 32'h1000_FFFE;
    img[9'h123] = 32'hFC00_0123;
    do_reset();
    send_word(32'd292);
    for (int i = 0; i < 292; i++) send_word(img[i]);
    wait_valid("c_valid", cyc);
    check("c_pc0", 32'(pc), 32'd0);
    commit("c_seq1", 2'b00, 1'b0, '0, 14'd1, 32'h0000_0000);
    commit("c_seq2", 2'b00, 1'b0, '0, 14'd2, 32'h0000_0000);
    commit("c_seq3", 2'b00, 1'b0, '0, 14'd3, 32'h0800_0005);
    check("c_retired3", retired, CNT_EN ? 32'd3 : 32'd0);
    commit("c_jump", 2'b10, 1'b0, '0, 14'd5, 32'h1000_FFFE);
    commit("c_br_taken", 2'b11, 1'b1, '0, 14'd4, 32'h0800_0005);
    commit("c_jump_back", 2'b10, 1'b0, '0, 14'd5, 32'h1000_FFFE);
    commit("c_br_not", 2'b11, 1'b0, '0, 14'd6, 32'h0000_0000);
    commit("c_jr", 2'b01, 1'b0, 14'h123, 14'h123, 32'hFC00_0123);
    check("c_jr_opecode", 32'(opecode), 32'h3F);
    check("c_link", 32'(link_pc), 32'h124);
    write_pc = 1'b1; cp_type = 2'b01;
    tick();
    write_pc = 1'b0;
    check("c_halt_running", 32'(running), 32'd0);
    check("c_halt_pc", 32'(pc), 32'h123);
    check("c_retired", retired, CNT_EN ? 32'd9 : 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
